// File: rtl/debug_step_controller.sv
// debug_step_controller: decodes UART debug commands and sequences the gated pipeline clock, pipeline reset and state dumps.
// Ports:
//   clock, reset          system clock; synchronous active-low reset
//   rx_ready, r_data      UART receive byte and its valid flag
//   rd_uart               combinational byte-consume strobe back to the UART
//   program_finished      end-of-program flag from the pipeline
//   pc_ifid               IF/ID PC compared against the breakpoint
//   dataSent, sendSignal  dump handshake: sendSignal starts a dump, dataSent ends it
//   pipelineClk           gated pipeline clock (registered)
//   pipelineReset         active-high pipeline reset (registered)
//   cycle_count           saturating count of pipeline cycles since the last pipeline reset
//   stop_cause            0 step/dump, 1 finished, 2 breakpoint, 3 halt
//   current_state         FSM state encoding
module debug_step_controller #(
  parameter int         CLK_HALF   = 4,
  parameter int         PC_W       = 10,
  parameter logic [7:0] CMD_STEP   = 8'h73,
  parameter logic [7:0] CMD_RUN    = 8'h72,
  parameter logic [7:0] CMD_HALT   = 8'h68,
  parameter logic [7:0] CMD_BRK    = 8'h62,
  parameter logic [7:0] CMD_CLRBRK = 8'h63,
  parameter logic [7:0] CMD_PRST   = 8'h78,
  parameter logic [7:0] CMD_DUMP   = 8'h64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            rx_ready,
  input  logic [7:0]      r_data,
  output logic            rd_uart,
  input  logic            program_finished,
  input  logic [PC_W-1:0] pc_ifid,
  input  logic            dataSent,
  output logic            sendSignal,
  output logic            pipelineClk,
  output logic            pipelineReset,
  output logic [15:0]     cycle_count,
  output logic [1:0]      stop_cause,
  output logic [2:0]      current_state
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] PRST      = 3'd1;
  localparam logic [2:0] CLK_HIGH  = 3'd2;
  localparam logic [2:0] CLK_LOW   = 3'd3;
  localparam logic [2:0] DUMP_REQ  = 3'd4;
  localparam logic [2:0] DUMP_WAIT = 3'd5;
  localparam logic [2:0] BP_HI     = 3'd6;
  localparam logic [2:0] BP_LO     = 3'd7;
  localparam logic [1:0] M_STEP  = 2'd0;
  localparam logic [1:0] M_RUN   = 2'd1;
  localparam logic [1:0] M_RESET = 2'd2;
  localparam int CW = $clog2(CLK_HALF + 1);
  logic [2:0]      state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PC_W-1:0] bp_q, bp_d;
  logic            bp_valid_q, bp_valid_d;
  logic [15:0]     cycle_count_q, cycle_count_d;
  logic [1:0]      stop_cause_q, stop_cause_d;
  logic            pipelineClk_q, pipelineClk_d;
  logic            pipelineReset_q, pipelineReset_d;
  logic            sendSignal_q, sendSignal_d;
  logic            take;
  logic            last;
  assign last = cnt_q == CW'(CLK_HALF - 1);
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    bp_d          = bp_q;
    bp_valid_d    = bp_valid_q;
    cycle_count_d = cycle_count_q;
    stop_cause_d  = stop_cause_q;
    take          = 1'b0;
    case (state_q)
      IDLE: if (rx_ready) begin
        take = 1'b1;
        if (r_data == CMD_STEP || r_data == CMD_RUN) begin
          // a finished program is never clocked again; report it straight away
          if (program_finished) begin
            stop_cause_d = 2'd1;
            state_d      = DUMP_REQ;
          end else begin
            mode_d  = (r_data == CMD_STEP) ? M_STEP : M_RUN;
            state_d = CLK_HIGH;
          end
        end else if (r_data == CMD_PRST) state_d = PRST;
        else if (r_data == CMD_DUMP) begin
          stop_cause_d = 2'd0;
          state_d      = DUMP_REQ;
        end else if (r_data == CMD_BRK) state_d = BP_HI;
        else if (r_data == CMD_CLRBRK) bp_valid_d = 1'b0;
      end
      PRST: begin
        mode_d  = M_RESET;
        state_d = CLK_HIGH;
      end
      CLK_HIGH: if (last) begin
        state_d = CLK_LOW;
        if (mode_q != M_RESET && cycle_count_q != 16'hFFFF) cycle_count_d = cycle_count_q + 16'd1;
      end
      CLK_LOW: if (last) begin
        if (mode_q == M_RESET) begin
          cycle_count_d = '0;
          state_d       = IDLE;
        end else if (mode_q == M_STEP) begin
          stop_cause_d = 2'd0;
          state_d      = DUMP_REQ;
        end else if (program_finished) begin
          stop_cause_d = 2'd1;
          state_d      = DUMP_REQ;
        end else if (bp_valid_q && pc_ifid == bp_q) begin
          stop_cause_d = 2'd2;
          state_d      = DUMP_REQ;
        end else if (rx_ready && r_data == CMD_HALT) begin
          // only a halt byte is consumed mid-run; anything else waits for IDLE
          take         = 1'b1;
          stop_cause_d = 2'd3;
          state_d      = DUMP_REQ;
        end else state_d = CLK_HIGH;
      end
      DUMP_REQ: state_d = DUMP_WAIT;
      DUMP_WAIT: if (dataSent) state_d = IDLE;
      BP_HI: if (rx_ready) begin
        take             = 1'b1;
        bp_d[PC_W-1:8]   = r_data[PC_W-9:0];
        state_d          = BP_LO;
      end
      BP_LO: if (rx_ready) begin
        take       = 1'b1;
        bp_d[7:0]  = r_data;
        bp_valid_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // the phase counter restarts on every state change, so each clock phase lasts CLK_HALF cycles
    cnt_d           = (state_d == state_q) ? cnt_q + 1'b1 : '0;
    pipelineClk_d   = state_d == CLK_HIGH;
    pipelineReset_d = state_d == PRST || (mode_d == M_RESET && (state_d == CLK_HIGH || state_d == CLK_LOW));
    sendSignal_d    = state_d == DUMP_REQ;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= PRST;
      mode_q          <= M_RESET;
      cnt_q           <= '0;
      bp_q            <= '0;
      bp_valid_q      <= 1'b0;
      cycle_count_q   <= '0;
      stop_cause_q    <= '0;
      pipelineClk_q   <= 1'b0;
      pipelineReset_q <= 1'b1;
      sendSignal_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      mode_q          <= mode_d;
      cnt_q           <= cnt_d;
      bp_q            <= bp_d;
      bp_valid_q      <= bp_valid_d;
      cycle_count_q   <= cycle_count_d;
      stop_cause_q    <= stop_cause_d;
      pipelineClk_q   <= pipelineClk_d;
      pipelineReset_q <= pipelineReset_d;
      sendSignal_q    <= sendSignal_d;
    end
  end
  assign rd_uart       = reset & take;
  assign sendSignal    = sendSignal_q;
  assign pipelineClk   = pipelineClk_q;
  assign pipelineReset = pipelineReset_q;
  assign cycle_count   = cycle_count_q;
  assign stop_cause    = stop_cause_q;
  assign current_state = state_q;
endmodule

// File: tb/tb_debug_step_controller.sv
// tb_debug_step_controller: randomized self-checking bench for debug_step_controller against a command-level model.
module tb_debug_step_controller;
  localparam int H  = 4;
  localparam int PW = 10;
  localparam logic [7:0] C_STEP = 8'h73, C_RUN = 8'h72, C_HALT = 8'h68, C_BRK = 8'h62;
  localparam logic [7:0] C_CLR = 8'h63, C_PRST = 8'h78, C_DUMP = 8'h64;
  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          rx_ready = 1'b0;
  logic [7:0]    r_data = 8'h00;
  logic          rd_uart;
  logic          program_finished = 1'b0;
  logic [PW-1:0] pc_ifid = '0;
  logic          dataSent = 1'b0;
  logic          sendSignal;
  logic          pipelineClk;
  logic          pipelineReset;
  logic [15:0]   cycle_count;
  logic [1:0]    stop_cause;
  logic [2:0]    current_state;
  debug_step_controller #(.CLK_HALF(H), .PC_W(PW)) dut (
    .clock(clock), .reset(reset), .rx_ready(rx_ready), .r_data(r_data), .rd_uart(rd_uart),
    .program_finished(program_finished), .pc_ifid(pc_ifid), .dataSent(dataSent),
    .sendSignal(sendSignal), .pipelineClk(pipelineClk), .pipelineReset(pipelineReset),
    .cycle_count(cycle_count), .stop_cause(stop_cause), .current_state(current_state)
  );
  always #5 clock = ~clock;
  int   n_checks = 0, n_fail = 0;
  int   pulses = 0, sends = 0, fin_at = 0, pulse_base = 0, exp_count = 0;
  logic prev_pclk = 1'b0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // advance one clock and model the pipeline: PC steps by 4 per pipeline clock, held at 0 in reset
  task automatic tick();
    @(posedge clock);
    #1;
    if (pipelineReset) pc_ifid = '0;
    else if (pipelineClk && !prev_pclk) pc_ifid = pc_ifid + PW'(4);
    if (pipelineClk && !prev_pclk) pulses++;
    prev_pclk = pipelineClk;
    if (sendSignal) sends++;
    if (fin_at != 0 && pulses - pulse_base >= fin_at) program_finished = 1'b1;
  endtask
  task automatic issue(input logic [7:0] b, input logic exp_rd);
    rx_ready = 1'b1;
    r_data   = b;
    #1;
    check("rd_uart", 32'(rd_uart), 32'(exp_rd));
    tick();
    rx_ready = 1'b0;
  endtask
  task automatic wait_state(input logic [2:0] s, input int bound);
    int i = 0;
    while (current_state != s && i < bound) begin
      tick();
      i++;
    end
    if (current_state != s) check("wait_timeout", 32'(current_state), 32'(s));
  endtask
  task automatic reset_seq();
    int   rc = 0, hc = 0, ed = 0, s0 = sends;
    logic pp = pipelineClk;
    for (int i = 0; i < 40 && !(current_state == 3'd0 && !pipelineReset); i++) begin
      if (pipelineReset) rc++;
      if (pipelineClk) hc++;
      if (pipelineClk && !pp) ed++;
      pp = pipelineClk;
      tick();
    end
    check("rst_len", 32'(rc), 32'(2 * H + 1));
    check("rst_clk_high", 32'(hc), 32'(H));
    check("rst_clk_pulses", 32'(ed), 32'd1);
    check("rst_state", 32'(current_state), 32'd0);
    check("rst_count", 32'(cycle_count), 32'd0);
    check("rst_no_send", 32'(sends - s0), 32'd0);
    exp_count = 0;
  endtask
  task automatic finish_dump();
    wait_state(3'd5, 50);
    repeat ($urandom_range(0, 3)) tick();
    check("dump_hold", 32'(current_state), 32'd5);
    dataSent = 1'b1;
    tick();
    dataSent = 1'b0;
    check("dump_idle", 32'(current_state), 32'd0);
  endtask
  task automatic do_step();
    int first = -1, last = -1, snd = -1, s0 = sends;
    issue(C_STEP, 1'b1);
    for (int t = 1; t <= 2 * H + 3; t++) begin
      if (pipelineClk) begin
        if (first < 0) first = t;
        last = t;
      end
      if (sendSignal && snd < 0) snd = t;
      tick();
    end
    exp_count++;
    check("step_clk_first", 32'(first), 32'd1);
    check("step_clk_last", 32'(last), 32'(H));
    check("step_send_at", 32'(snd), 32'(2 * H + 1));
    check("step_sends", 32'(sends - s0), 32'd1);
    check("step_count", 32'(cycle_count), 32'(exp_count));
    check("step_cause", 32'(stop_cause), 32'd0);
    finish_dump();
  endtask
  task automatic do_run(input int n, input int cause);
    int el = 1, s0 = sends;
    pulse_base = pulses;
    issue(C_RUN, 1'b1);
    while (!sendSignal && el < 5000) begin
      tick();
      el++;
    end
    exp_count += n;
    check("run_send_at", 32'(el), 32'(2 * H * n + 1));
    check("run_pulses", 32'(pulses - pulse_base), 32'(n));
    check("run_cause", 32'(stop_cause), 32'(cause));
    check("run_count", 32'(cycle_count), 32'(exp_count));
    finish_dump();
    check("run_sends", 32'(sends - s0), 32'd1);
  endtask
  task automatic set_bp(input logic [PW-1:0] v);
    logic [7:0] hi;
    hi = {6'($urandom), v[PW-1:8]};
    issue(C_BRK, 1'b1);
    check("bp_hi_state", 32'(current_state), 32'd6);
    repeat ($urandom_range(0, 2)) tick();
    check("bp_hi_wait", 32'(current_state), 32'd6);
    issue(hi, 1'b1);
    check("bp_lo_state", 32'(current_state), 32'd7);
    issue(v[7:0], 1'b1);
    check("bp_done_state", 32'(current_state), 32'd0);
  endtask
  task automatic do_halt();
    int s, off = 1, fr = -1, exp_off, base;
    s    = $urandom_range(2, 6 * H);
    base = pulses;
    issue(C_RUN, 1'b1);
    rx_ready = 1'b1;
    r_data   = 8'h41;
    while (off < 200 && fr < 0) begin
      if (off >= s) r_data = C_HALT;
      #1;
      if (rd_uart) fr = off;
      tick();
      off++;
    end
    rx_ready  = 1'b0;
    exp_off   = ((s + 2 * H - 1) / (2 * H)) * 2 * H;
    exp_count = exp_off / (2 * H);
    check("halt_take_at", 32'(fr), 32'(exp_off));
    check("halt_send", 32'(sendSignal), 32'd1);
    check("halt_cause", 32'(stop_cause), 32'd3);
    check("halt_count", 32'(cycle_count), 32'(exp_count));
    check("halt_pulses", 32'(pulses - base), 32'(exp_count));
    finish_dump();
  endtask
  initial begin
    int n, base, s0;
    rx_ready = 1'b1;
    r_data   = C_STEP;
    repeat (3) tick();
    check("hold_rd_uart", 32'(rd_uart), 32'd0);
    rx_ready = 1'b0;
    check("hold_state", 32'(current_state), 32'd1);
    check("hold_preset", 32'(pipelineReset), 32'd1);
    check("hold_pclk", 32'(pipelineClk), 32'd0);
    check("hold_send", 32'(sendSignal), 32'd0);
    check("hold_count", 32'(cycle_count), 32'd0);
    check("hold_cause", 32'(stop_cause), 32'd0);
    reset = 1'b1;
    reset_seq();
    for (int it = 0; it < 3; it++) begin
      repeat ($urandom_range(1, 3)) do_step();
      issue(C_DUMP, 1'b1);
      check("dump_cmd_send", 32'(sendSignal), 32'd1);
      check("dump_cmd_cause", 32'(stop_cause), 32'd0);
      finish_dump();
      issue(C_PRST, 1'b1);
      reset_seq();
      n = $urandom_range(2, 6);
      set_bp(PW'(4 * n));
      do_run(n, 2);
      issue(C_PRST, 1'b1);
      reset_seq();
      n = $urandom_range(2, 6);
      set_bp(PW'(4 * n));
      fin_at = n;
      do_run(n, 1);
      base = pulses;
      s0   = sends;
      issue(C_STEP, 1'b1);
      check("fin_step_send", 32'(sendSignal), 32'd1);
      check("fin_step_clk", 32'(pipelineClk), 32'd0);
      check("fin_step_cause", 32'(stop_cause), 32'd1);
      check("fin_step_count", 32'(cycle_count), 32'(exp_count));
      finish_dump();
      check("fin_step_pulses", 32'(pulses - base), 32'd0);
      check("fin_step_sends", 32'(sends - s0), 32'd1);
      fin_at           = 0;
      program_finished = 1'b0;
      issue(C_CLR, 1'b1);
      check("clr_state", 32'(current_state), 32'd0);
      issue(C_PRST, 1'b1);
      reset_seq();
      do_halt();
      issue(8'h41, 1'b1);
      check("junk_state", 32'(current_state), 32'd0);
    end
    set_bp(PW'(8));
    issue(C_STEP, 1'b1);
    tick();
    check("mid_high_clk", 32'(pipelineClk), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mid_rst_clk", 32'(pipelineClk), 32'd0);
    check("mid_rst_preset", 32'(pipelineReset), 32'd1);
    check("mid_rst_count", 32'(cycle_count), 32'd0);
    check("mid_rst_state", 32'(current_state), 32'd1);
    reset_seq();
    fin_at = 4;
    do_run(4, 1);
    fin_at           = 0;
    program_finished = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/debug_step_controller.md
# debug_step_controller

Sequencing controller for the debug-mode pipeline. It decodes command bytes from the UART receiver and generates the gated pipeline clock and pipeline reset. It runs the pipeline in single-step or free-run mode, stopping on end-of-program, PC breakpoint or host halt. After each step or stop it requests a full state dump from the debugger transmitter and waits for its completion handshake.

## Interface
Parameters:
- CLK_HALF, 4: system clocks per pipelineClk phase (high and low); ≥1
- PC_W, 10: pipeline PC width
- CMD_STEP, 8'h73: 's', execute one pipeline cycle then dump
- CMD_RUN, 8'h72: 'r', run until stop condition then dump
- CMD_HALT, 8'h68: 'h', stop a run
- CMD_BRK, 8'h62: 'b', set breakpoint; followed by hi byte (bits [PC_W-9:0] used), then lo byte
- CMD_CLRBRK, 8'h63: 'c', clear breakpoint
- CMD_PRST, 8'h78: 'x', reset pipeline
- CMD_DUMP, 8'h64: 'd', dump without clocking

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low
- rx_ready  in  1  UART byte available
- r_data  in  8  UART received byte
- rd_uart  out  1  consume current byte; UART clears rx_ready on the same edge
- program_finished  in  1  end-of-program flag from end detector
- pc_ifid  in  PC_W  IF/ID PC for breakpoint compare
- dataSent  in  1  one-cycle pulse: dump transmission complete
- sendSignal  out  1  one-cycle pulse: start dump
- pipelineClk  out  1  gated pipeline clock
- pipelineReset  out  1  active-high pipeline reset
- cycle_count  out  16  pipeline cycles executed since last pipeline reset, saturating at 16'hFFFF
- stop_cause  out  2  0 step/dump, 1 finished, 2 breakpoint, 3 halt
- current_state  out  3  FSM state encoding

## Operation
- States and encodings: IDLE=0, PRST=1, CLK_HIGH=2, CLK_LOW=3, DUMP_REQ=4, DUMP_WAIT=5, BP_HI=6, BP_LO=7.
- Internal mode register: STEP, RUN or RESET.
- rd_uart = rx_ready while in IDLE, BP_HI or BP_LO. It is not registered. Bytes are decoded in the same cycle.

IDLE, on a consumed byte:
- CMD_STEP: mode STEP → CLK_HIGH.
- CMD_RUN: mode RUN → CLK_HIGH.
- CMD_STEP or CMD_RUN with program_finished=1: no clocking. stop_cause=1 → DUMP_REQ.
- CMD_PRST → PRST.
- CMD_DUMP: stop_cause=0 → DUMP_REQ.
- CMD_BRK → BP_HI.
- CMD_CLRBRK: bp_valid←0, stay in IDLE.
- Any other byte is consumed and ignored.

BP_HI / BP_LO:
- BP_HI waits for rx_ready, then latches bp[PC_W-1:8] from r_data[PC_W-9:0] → BP_LO.
- BP_LO waits for rx_ready, then latches bp[7:0] and sets bp_valid←1 → IDLE.

PRST:
- One cycle; pipelineReset=1, mode RESET → CLK_HIGH.

Clock phases:
- CLK_HIGH: pipelineClk=1 for CLK_HALF cycles → CLK_LOW. cycle_count increments on leaving CLK_HIGH in STEP/RUN modes.
- CLK_LOW: pipelineClk=0 for CLK_HALF cycles. The stop check happens in the last cycle of CLK_LOW:
  - RESET mode: pipelineReset←0, cycle_count←0 → IDLE (no dump).
  - STEP mode: stop_cause=0 → DUMP_REQ.
  - RUN mode, priority order: program_finished → 1; bp_valid && pc_ifid==bp → 2; rx_ready && r_data==CMD_HALT → 3 (rd_uart pulses this cycle only). Any hit → DUMP_REQ; otherwise → CLK_HIGH.
  - Other bytes arriving during RUN are left unconsumed.
- The breakpoint is checked only after ≥1 executed cycle, so a run starting at the breakpoint PC proceeds.

Dump:
- DUMP_REQ: sendSignal=1 for one cycle → DUMP_WAIT.
- DUMP_WAIT: on dataSent=1 → IDLE.

Reset:
- reset=0 in any state forces state PRST with mode RESET and phase counter 0.
- Reset values while held: pipelineReset=1, pipelineClk=0, sendSignal=0, rd_uart=0, cycle_count=0, stop_cause=0, bp=0, bp_valid=0.
- After release, a full reset sequence (one pipelineClk pulse under reset) runs automatically.

## Timing
- pipelineClk, pipelineReset and sendSignal are registered; their changes track state entry.
- Step, with the command seen at cycle T:
  - rd_uart=1 at T.
  - pipelineClk=1 at T+1..T+CLK_HALF.
  - pipelineClk=0 from T+CLK_HALF+1.
  - sendSignal=1 at T+2·CLK_HALF+1.
- Run: one pipeline cycle per 2·CLK_HALF clocks, with no gap between cycles.
- Dump completion: IDLE is entered the cycle after dataSent.
- Reset sequence after release: pipelineReset=1 for 2·CLK_HALF+1 cycles, enclosing exactly one pipelineClk high phase.

## Test plan
- Release reset with CLK_HALF=4: pipelineReset high 9 cycles; one pipelineClk pulse, 4 cycles wide; then IDLE (state 0), cycle_count=0, sendSignal never asserted.
- 's' at T: rd_uart at T; pipelineClk high T+1..T+4; sendSignal at T+9; cycle_count=1; stop_cause=0; IDLE one cycle after a dataSent pulse.
- 'b',0x00,0x0C then 'r', bench advancing pc_ifid by 4 per pipeline cycle from 0: run stops after pc_ifid=0x00C is seen, stop_cause=2, cycle_count=3, single sendSignal.
- 'r' with program_finished and the breakpoint match both true at the end of cycle 5: stop_cause=1, cycle_count=5. A following 's' gives no pipelineClk pulse and an immediate sendSignal.
- 'r' then 'h' mid-run: the current pipeline cycle completes, rd_uart pulses at its last CLK_LOW cycle, stop_cause=3. A byte 0x41 in IDLE is consumed and the state stays 0.
- reset=0 for one cycle during CLK_HIGH: the next cycle shows pipelineClk=0, pipelineReset=1, cycle_count=0, bp_valid=0; the full reset sequence follows.
